lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
Pipelined load/store unit for the MIPS core, placed between the EX/MEM stage and the SRAM-like data bus (req/addr_ok/data_ok). It turns one memory op per accepted request into a bus transaction with byte strobes and lane-shifted store data, and checks address alignment. It keeps up to DEPTH transactions in flight and returns in-order responses with load data already extracted, sign/zero-extended or merged (LWL/LWR). It supports flush of in-flight work on exceptions.

Parameters:
ADDR_W, 32, address width
DEPTH, 2, max outstanding transactions (power of 2, >=2)
TAG_W, 5, opaque per-request tag (dest reg) returned with response

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_op  in  4  LSU_OP_* code
req_addr  in  ADDR_W  effective address
req_wdata  in  32  store source (rt)
req_rtdata  in  32  old rt for LWL/LWR merge
req_tag  in  TAG_W  returned unchanged
flush  in  1  discard all queued/in-flight work
bus_req  out  1  bus request
bus_wr  out  1  1=store
bus_size  out  2  0 byte, 1 half, 2 word
bus_wstrb  out  4  byte strobes (0 for loads)
bus_addr  out  ADDR_W  bus address
bus_wdata  out  32  lane-aligned store data
bus_addr_ok  in  1  request taken this cycle
bus_data_ok  in  1  response this cycle, in order
bus_rdata  in  32  load data
resp_valid  out  1  one-cycle pulse, no backpressure
resp_data  out  32  final register value (0 for stores)
resp_tag  out  TAG_W  tag of responding op
resp_exc  out  1  address error (AdEL/AdES)
resp_badvaddr  out  ADDR_W  faulting address

Behaviour:
- Reset: all outputs 0, queue empty, discard counter 0.
- Ops: LB LBU LH LHU LW LWL LWR SB SH SW SWL SWR. a = req_addr[1:0].
- Align error: LH/LHU/SH with a[0]!=0, LW/SW with a!=0. No bus request. Entry is queued with exc=1.
- req_ready = !flush && queue not full && (!bus_req || bus_addr_ok).
- Acceptance in cycle N: queue entry {op, a, rtdata, tag, exc, addr} is written. Unless exc, bus_* are registered and bus_req=1 in cycle N+1. Outputs hold stable until bus_addr_ok. Entry is marked issued on addr_ok.
- Bus fields: LB/LBU/SB size 0. LH/LHU/SH size 1. Others size 2. LWL/LWR/SWL/SWR use bus_addr = addr & ~3; all other ops use bus_addr = addr.
- Strobes: SB 1<<a. SH a=0 ->0011, a=2 ->1100. SW 1111. SWL a=0..3 -> 0001, 0011, 0111, 1111. SWR a=0..3 -> 1111, 1110, 1100, 1000.
- Store data: SB/SH/SW/SWR = wdata << 8a. SWL = wdata >> (24-8a).
- Load data: bytes/halves = rdata >> 8a, then extended.
- LWL merge, a=0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
- LWR merge, a=0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
- Responses strictly in queue order. For an issued head entry, resp_valid rises the cycle after bus_data_ok and the entry is popped. For an exc head entry, resp_valid rises the cycle after it becomes head, with resp_exc=1 and resp_badvaddr=addr.
- Simultaneous accept and pop in the same cycle: both take effect, so a full queue with a pop does not accept (ready is computed before the pop).
- Flush: queue is cleared next cycle; no resp_valid for any flushed entry; flush blocks acceptance.
- Flush while bus_req is held without addr_ok: bus_req stays asserted until addr_ok, that transaction counts toward discard, and the entry is not re-queued.
- Discard counter: on flush it loads the number of issued-but-unanswered transactions, plus 1 if the held request completes later. While the counter is nonzero, each bus_data_ok decrements it and is dropped. req_ready is also 0 while it is nonzero.
- Reset mid-transaction: everything is cleared immediately; bus-side recovery is the bus owner's responsibility.

Decomposition:
- defines.h gets the LSU_OP_* codes (4-bit), LSU_SIZE_* codes, and the AdEL/AdES excode constants.
- Sub-module lsu_queue: parametrised DEPTH circular FIFO with separate issue and head pointers, full/empty flags, and a clear input.

Test Plan:
- LB addr 0x1003, rdata 0x80AA5511 -> bus_size 0, bus_addr 0x1003, resp_data 0xFFFFFF80. LBU same -> 0x00000080.
- LWL addr 0x2001, rdata 0x11223344, rtdata 0xAABBCCDD -> bus_addr 0x2000, resp_data 0x3344CCDD. LWR addr 0x2001 same data -> 0xAA112233.
- SWR addr 0x3002, wdata 0x11223344 -> bus_wstrb 1100, bus_wdata 0x33440000. SWL addr 0x3001 -> wstrb 0011, wdata 0x00001122.
- LW addr 0x1002 -> no bus_req, resp_valid next cycle with resp_exc=1, badvaddr 0x1002. SH 0x1001 gives the same result.
- DEPTH=2, three back-to-back loads with addr_ok immediate and data_ok withheld -> third load sees req_ready=0 until the first data_ok. Responses return in order with correct tags.
- Two loads issued, flush, then two data_ok -> no resp_valid, req_ready=0 until the second data_ok, then 1.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store unit memory port: op codes,
// bus size codes, address-error exception codes and the pure decode /
// lane-steering helpers used by both the request and response paths.
package lsu_mem_port_pkg;

  localparam logic [3:0] LSU_OP_LB  = 4'd0;
  localparam logic [3:0] LSU_OP_LBU = 4'd1;
  localparam logic [3:0] LSU_OP_LH  = 4'd2;
  localparam logic [3:0] LSU_OP_LHU = 4'd3;
  localparam logic [3:0] LSU_OP_LW  = 4'd4;
  localparam logic [3:0] LSU_OP_LWL = 4'd5;
  localparam logic [3:0] LSU_OP_LWR = 4'd6;
  localparam logic [3:0] LSU_OP_SB  = 4'd7;
  localparam logic [3:0] LSU_OP_SH  = 4'd8;
  localparam logic [3:0] LSU_OP_SW  = 4'd9;
  localparam logic [3:0] LSU_OP_SWL = 4'd10;
  localparam logic [3:0] LSU_OP_SWR = 4'd11;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSU_SIZE_WORD = 2'd2;

  localparam logic [4:0] LSU_EXC_ADEL = 5'h04;
  localparam logic [4:0] LSU_EXC_ADES = 5'h05;

  // Store-class ops drive bus_wr and return zero as register value.
  function automatic logic lsu_is_store(input logic [3:0] op);
    case (op)
      LSU_OP_SB, LSU_OP_SH, LSU_OP_SW, LSU_OP_SWL, LSU_OP_SWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Exception code the pipeline reports for a misaligned op.
  function automatic logic [4:0] lsu_exc_code(input logic [3:0] op);
    return lsu_is_store(op) ? LSU_EXC_ADES : LSU_EXC_ADEL;
  endfunction

  function automatic logic [1:0] lsu_size(input logic [3:0] op);
    case (op)
      LSU_OP_LB, LSU_OP_LBU, LSU_OP_SB: return LSU_SIZE_BYTE;
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: return LSU_SIZE_HALF;
      default: return LSU_SIZE_WORD;
    endcase
  endfunction

  // Unaligned word ops always access the containing aligned word.
  function automatic logic lsu_word_base(input logic [3:0] op);
    case (op)
      LSU_OP_LWL, LSU_OP_LWR, LSU_OP_SWL, LSU_OP_SWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: return a[0];
      LSU_OP_LW, LSU_OP_SW: return (a != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_wstrb(input logic [3:0] op, input logic [1:0] a);
    case (op)
      LSU_OP_SB: return 4'b0001 << a;
      LSU_OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      LSU_OP_SW: return 4'b1111;
      LSU_OP_SWL: begin
        case (a)
          2'd0: return 4'b0001;
          2'd1: return 4'b0011;
          2'd2: return 4'b0111;
          default: return 4'b1111;
        endcase
      end
      LSU_OP_SWR: return 4'b1111 << a;
      default: return 4'b0000;
    endcase
  endfunction

  // SWL carries the high bytes of rt down to the low lanes; every other
  // store shifts rt up to the addressed lane.
  function automatic logic [31:0] lsu_wdata(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] wdata);
    case (op)
      LSU_OP_SB, LSU_OP_SH, LSU_OP_SW, LSU_OP_SWR: return wdata << {a, 3'b000};
      LSU_OP_SWL: return wdata >> (5'd24 - {a, 3'b000});
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] lsu_load_result(input logic [3:0] op, input logic [1:0] a,
                                                  input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (op)
      LSU_OP_LB:  return {{24{sh[7]}}, sh[7:0]};
      LSU_OP_LBU: return {24'd0, sh[7:0]};
      LSU_OP_LH:  return {{16{sh[15]}}, sh[15:0]};
      LSU_OP_LHU: return {16'd0, sh[15:0]};
      LSU_OP_LW:  return rd;
      LSU_OP_LWL: begin
        case (a)
          2'd0: return {rd[7:0], rt[23:0]};
          2'd1: return {rd[15:0], rt[15:0]};
          2'd2: return {rd[23:0], rt[7:0]};
          default: return rd;
        endcase
      end
      LSU_OP_LWR: begin
        case (a)
          2'd0: return rd;
          2'd1: return {rt[31:24], rd[31:8]};
          2'd2: return {rt[31:16], rd[31:16]};
          default: return {rt[31:8], rd[31:24]};
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_queue.sv
// In-order transaction queue for the LSU. Entries are pushed at the tail,
// marked issued when the bus takes their request, filled when their read
// data returns, and popped from the head. The issue and fill targets are
// the oldest entries still waiting for that step.
module lsu_queue #(
  parameter int DEPTH = 2,
  parameter int PAY_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [PAY_W-1:0] push_pay,
  input  logic             push_exc,
  input  logic             pop,
  input  logic             mark_issue,
  input  logic             fill,
  input  logic [31:0]      fill_data,
  output logic             full,
  output logic             empty,
  output logic [PAY_W-1:0] head_pay,
  output logic             head_exc,
  output logic             head_done,
  output logic [31:0]      head_rdata,
  output logic             fill_at_head,
  output logic [CNT_W-1:0] pend_cnt
);

  logic [PAY_W-1:0] pay_r   [DEPTH];
  logic [31:0]      rdata_r [DEPTH];
  logic [DEPTH-1:0] exc_r;
  logic [DEPTH-1:0] issued_r;
  logic [DEPTH-1:0] done_r;
  logic [PTR_W-1:0] head_ptr_r;
  logic [PTR_W-1:0] tail_ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [PTR_W-1:0] issue_ptr_s;
  logic [PTR_W-1:0] fill_ptr_s;
  logic             issue_hit_s;
  logic             fill_hit_s;
  logic [PTR_W-1:0] scan_idx_s;
  logic             in_q_s;
  logic             take_iss_s;
  logic             take_fill_s;

  // Walk from head to find the oldest unissued and oldest unfilled entries.
  always_comb begin
    issue_ptr_s = head_ptr_r;
    fill_ptr_s  = head_ptr_r;
    issue_hit_s = 1'b0;
    fill_hit_s  = 1'b0;
    pend_cnt    = {CNT_W{1'b0}};
    scan_idx_s  = head_ptr_r;
    in_q_s      = 1'b0;
    take_iss_s  = 1'b0;
    take_fill_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s  = head_ptr_r + PTR_W'(i);
      in_q_s      = (CNT_W'(i) < cnt_r);
      take_iss_s  = in_q_s && !exc_r[scan_idx_s] && !issued_r[scan_idx_s] && !issue_hit_s;
      take_fill_s = in_q_s && issued_r[scan_idx_s] && !done_r[scan_idx_s] && !fill_hit_s;
      issue_ptr_s = take_iss_s ? scan_idx_s : issue_ptr_s;
      fill_ptr_s  = take_fill_s ? scan_idx_s : fill_ptr_s;
      issue_hit_s = issue_hit_s | take_iss_s;
      fill_hit_s  = fill_hit_s | take_fill_s;
      pend_cnt    = pend_cnt + CNT_W'(in_q_s && issued_r[scan_idx_s] && !done_r[scan_idx_s]);
    end
  end

  assign full         = (cnt_r == CNT_W'(DEPTH));
  assign empty        = (cnt_r == {CNT_W{1'b0}});
  assign head_pay     = pay_r[head_ptr_r];
  assign head_exc     = exc_r[head_ptr_r];
  assign head_done    = done_r[head_ptr_r];
  assign head_rdata   = rdata_r[head_ptr_r];
  assign fill_at_head = fill_hit_s && (fill_ptr_s == head_ptr_r);

  // Pointer, occupancy and per-entry progress state; clear drops all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      exc_r      <= {DEPTH{1'b0}};
      issued_r   <= {DEPTH{1'b0}};
      done_r     <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pay_r[i]   <= {PAY_W{1'b0}};
        rdata_r[i] <= 32'd0;
      end
    end else if (clear) begin
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      exc_r      <= {DEPTH{1'b0}};
      issued_r   <= {DEPTH{1'b0}};
      done_r     <= {DEPTH{1'b0}};
    end else begin
      if (push) begin
        pay_r[tail_ptr_r]    <= push_pay;
        exc_r[tail_ptr_r]    <= push_exc;
        issued_r[tail_ptr_r] <= 1'b0;
        done_r[tail_ptr_r]   <= 1'b0;
        tail_ptr_r           <= tail_ptr_r + PTR_W'(1);
      end
      if (mark_issue && issue_hit_s) begin
        issued_r[issue_ptr_s] <= 1'b1;
      end
      if (fill && fill_hit_s) begin
        done_r[fill_ptr_s]  <= 1'b1;
        rdata_r[fill_ptr_s] <= fill_data;
      end
      if (pop) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1);
      end
      cnt_r <= cnt_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: converts accepted LSU ops into SRAM-like bus
// transactions, tracks up to DEPTH of them in order, and returns finished
// register values (or address errors) as single-cycle responses. A flush
// drops queued work and swallows any bus responses still owed to it.
module lsu_mem_port #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rtdata,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_exc,
  output logic [ADDR_W-1:0] resp_badvaddr
);

  import lsu_mem_port_pkg::*;

  localparam int PAY_W  = 4 + 2 + 32 + TAG_W + ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DISC_W = CNT_W + 1;

  logic [1:0]        acc_a_s;
  logic              acc_misalign_s;
  logic              accept_s;
  logic              fill_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [PAY_W-1:0]  head_pay_s;
  logic              head_exc_s;
  logic              head_done_s;
  logic [31:0]       head_rdata_s;
  logic              fill_at_head_s;
  logic [CNT_W-1:0]  pend_cnt_s;
  logic [3:0]        head_op_s;
  logic [1:0]        head_a_s;
  logic [31:0]       head_rt_s;
  logic [TAG_W-1:0]  head_tag_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [31:0]       head_rd_s;
  logic [DISC_W-1:0] discard_cnt_r;
  logic [DISC_W-1:0] discard_nxt_s;
  logic              orphan_r;

  assign acc_a_s        = req_addr[1:0];
  assign acc_misalign_s = lsu_misaligned(req_op, acc_a_s);

  // Ready is evaluated against the queue as it stands this cycle, before any pop.
  assign req_ready = !flush && !full_s && (!bus_req || bus_addr_ok)
                     && (discard_cnt_r == {DISC_W{1'b0}});
  assign accept_s  = req_valid && req_ready;

  // Read data belongs to flushed work while the discard counter is nonzero.
  assign fill_s = bus_data_ok && (discard_cnt_r == {DISC_W{1'b0}});

  assign {head_op_s, head_a_s, head_rt_s, head_tag_s, head_addr_s} = head_pay_s;

  // Data arriving for the head entry is used directly to save a cycle.
  assign head_rd_s = (fill_s && fill_at_head_s) ? bus_rdata : head_rdata_s;
  assign pop_s     = !flush && !empty_s
                     && (head_exc_s || head_done_s || (fill_s && fill_at_head_s));

  lsu_queue #(
    .DEPTH (DEPTH),
    .PAY_W (PAY_W)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clear        (flush),
    .push         (accept_s),
    .push_pay     ({req_op, acc_a_s, req_rtdata, req_tag, req_addr}),
    .push_exc     (acc_misalign_s),
    .pop          (pop_s),
    .mark_issue   (bus_req && bus_addr_ok && !orphan_r),
    .fill         (fill_s),
    .fill_data    (bus_rdata),
    .full         (full_s),
    .empty        (empty_s),
    .head_pay     (head_pay_s),
    .head_exc     (head_exc_s),
    .head_done    (head_done_s),
    .head_rdata   (head_rdata_s),
    .fill_at_head (fill_at_head_s),
    .pend_cnt     (pend_cnt_s)
  );

  // Count bus responses still owed to flushed work, including a held request.
  always_comb begin
    discard_nxt_s = discard_cnt_r;
    if (flush) begin
      discard_nxt_s = discard_cnt_r + DISC_W'(pend_cnt_s) + DISC_W'(bus_req && !orphan_r);
    end else begin
      discard_nxt_s = discard_cnt_r;
    end
    if (bus_data_ok && (flush || (discard_cnt_r != {DISC_W{1'b0}}))
        && (discard_nxt_s != {DISC_W{1'b0}})) begin
      discard_nxt_s = discard_nxt_s - DISC_W'(1);
    end else begin
      discard_nxt_s = discard_nxt_s;
    end
  end

  // Discard counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_cnt_r <= {DISC_W{1'b0}};
    end else begin
      discard_cnt_r <= discard_nxt_s;
    end
  end

  // Remember that the request currently held on the bus belongs to flushed work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_r <= 1'b0;
    end else if (bus_req && bus_addr_ok) begin
      orphan_r <= 1'b0;
    end else if (flush && bus_req) begin
      orphan_r <= 1'b1;
    end
  end

  // Bus request register: load on a good accept, hold until addr_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_wstrb <= 4'd0;
      bus_addr  <= {ADDR_W{1'b0}};
      bus_wdata <= 32'd0;
    end else if (accept_s && !acc_misalign_s) begin
      bus_req   <= 1'b1;
      bus_wr    <= lsu_is_store(req_op);
      bus_size  <= lsu_size(req_op);
      bus_wstrb <= lsu_wstrb(req_op, acc_a_s);
      bus_addr  <= lsu_word_base(req_op) ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
      bus_wdata <= lsu_wdata(req_op, acc_a_s, req_wdata);
    end else if (bus_req && bus_addr_ok) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_wstrb <= 4'd0;
      bus_addr  <= {ADDR_W{1'b0}};
      bus_wdata <= 32'd0;
    end
  end

  // Response register: one-cycle pulse per popped head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_data     <= 32'd0;
      resp_tag      <= {TAG_W{1'b0}};
      resp_exc      <= 1'b0;
      resp_badvaddr <= {ADDR_W{1'b0}};
    end else if (pop_s) begin
      resp_valid    <= 1'b1;
      resp_data     <= head_exc_s ? 32'd0
                                  : lsu_load_result(head_op_s, head_a_s, head_rd_s, head_rt_s);
      resp_tag      <= head_tag_s;
      resp_exc      <= head_exc_s;
      resp_badvaddr <= head_exc_s ? head_addr_s : {ADDR_W{1'b0}};
    end else begin
      resp_valid    <= 1'b0;
      resp_data     <= 32'd0;
      resp_tag      <= {TAG_W{1'b0}};
      resp_exc      <= 1'b0;
      resp_badvaddr <= {ADDR_W{1'b0}};
    end
  end

endmodule
